// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, sweep checker states and widths.
package alu_pkg;

   localparam int OPW  = 2;
   localparam int DW   = 4;
   localparam int IDXW = OPW + 2 * DW;
   localparam int CNTW = IDXW + 1;
   localparam int FVW  = OPW + 3 * DW;

   typedef enum logic [OPW-1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_OR  = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_HALT = 2'b10,
      ST_DONE = 2'b11
   } state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden ALU: 4-bit add/sub (mod 16), AND, OR.
module alu_ref_model
   import alu_pkg::*;
(
   input  logic [OPW-1:0] s,
   input  logic [DW-1:0]  a,
   input  logic [DW-1:0]  b,
   output logic [DW-1:0]  y
);

   always_comb begin
      y = '0;
      unique case (alu_op_e'(s))
         OP_ADD:  y = a + b;
         OP_SUB:  y = a - b;
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/alu_sweep_checker.sv
// Drives all 1024 {s,a,b} vectors into an external ALU and checks
// each combinational result against the reference model.
module alu_sweep_checker
   import alu_pkg::*;
#(
   parameter bit STOP_ON_FAIL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic [OPW-1:0]   s,
   output logic [DW-1:0]    a,
   output logic [DW-1:0]    b,
   input  logic [DW-1:0]    y,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNTW-1:0]  err_cnt,
   output logic [FVW-1:0]   fail_vec
);

   state_e             r_state;
   state_e             w_nxt;
   logic [IDXW-1:0]    r_idx;
   logic [CNTW-1:0]    r_err;
   logic [FVW-1:0]     r_fvec;
   logic [DW-1:0]      w_gold;
   logic               w_mis;
   logic               w_last;
   logic               w_go;

   alu_ref_model u_ref (
      .s (r_idx[IDXW-1 -: OPW]),
      .a (r_idx[2*DW-1 -: DW]),
      .b (r_idx[DW-1:0]),
      .y (w_gold)
   );

   assign w_mis  = (r_state == ST_RUN) && (y != w_gold);
   assign w_last = (r_idx == {IDXW{1'b1}});
   assign w_go   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      unique case (r_state)
         ST_IDLE: if (start) w_nxt = ST_RUN;
         ST_RUN: begin
            if (STOP_ON_FAIL && w_mis) w_nxt = ST_HALT;
            else if (w_last)           w_nxt = ST_DONE;
         end
         ST_HALT: w_nxt = ST_DONE;
         ST_DONE: if (start) w_nxt = ST_RUN;
         default: w_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state == ST_RUN) || (r_state == ST_HALT);
      done = (r_state == ST_DONE);
      pass = done && (r_err == '0);
   end

   // Index holds on the last or failing vector so s,a,b stay visible.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx  <= '0;
         r_err  <= '0;
         r_fvec <= '0;
      end else if (w_go) begin
         r_idx  <= '0;
         r_err  <= '0;
         r_fvec <= '0;
      end else if (r_state == ST_RUN) begin
         if (w_nxt == ST_RUN) r_idx <= r_idx + 1'b1;
         if (w_mis) begin
            r_err <= r_err + 1'b1;
            if (r_err == '0) r_fvec <= {r_idx, y};
         end
      end
   end

   assign s        = r_idx[IDXW-1 -: OPW];
   assign a        = r_idx[2*DW-1 -: DW];
   assign b        = r_idx[DW-1:0];
   assign err_cnt  = r_err;
   assign fail_vec = r_fvec;

endmodule

// File: tb/tb_alu_sweep_checker.sv
// Directed bench: two checkers (run-to-end and stop-on-fail) each
// driving a bench ALU with selectable injected faults.
module tb_alu_sweep_checker;

   logic        clk;
   logic        rst_n;
   logic        start0, start1;
   logic [1:0]  s0, s1;
   logic [3:0]  a0, a1, b0, b1, y0, y1;
   logic        busy0, busy1, done0, done1, pass0, pass1;
   logic [10:0] err0, err1;
   logic [13:0] fv0, fv1;
   int          mode0, mode1;
   int          checks, fails;
   int          cyc;

   alu_sweep_checker #(.STOP_ON_FAIL(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0),
      .s(s0), .a(a0), .b(b0), .y(y0),
      .busy(busy0), .done(done0), .pass(pass0),
      .err_cnt(err0), .fail_vec(fv0)
   );

   alu_sweep_checker #(.STOP_ON_FAIL(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .s(s1), .a(a1), .b(b1), .y(y1),
      .busy(busy1), .done(done1), .pass(pass1),
      .err_cnt(err1), .fail_vec(fv1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] gold(input logic [1:0] op,
                                       input logic [3:0] x,
                                       input logic [3:0] z);
      logic [4:0] t;
      t = '0;
      case (op)
         2'd0: t = {1'b0, x} + {1'b0, z};
         2'd1: t = {1'b0, x} - {1'b0, z};
         2'd2: t = {1'b0, x & z};
         default: t = {1'b0, x | z};
      endcase
      return t[3:0];
   endfunction

   // mode 1: AND/OR swapped, 2: add gives a+b+1, 3: carry leaks on wrap
   function automatic logic [3:0] dut_alu(input logic [1:0] op,
                                          input logic [3:0] x,
                                          input logic [3:0] z,
                                          input int md);
      logic [3:0] r;
      r = gold(op, x, z);
      if (md == 1 && op == 2'd2) r = x | z;
      if (md == 1 && op == 2'd3) r = x & z;
      if (md == 2 && op == 2'd0) r = r + 4'd1;
      if (md == 3 && op == 2'd0 && x == 4'd15 && z == 4'd1) r = 4'd1;
      if (md == 3 && op == 2'd1 && x == 4'd0 && z == 4'd1) r = 4'd1;
      return r;
   endfunction

   always_comb y0 = dut_alu(s0, a0, b0, mode0);
   always_comb y1 = dut_alu(s1, a1, b1, mode1);

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Leaves the bench at the negedge inside cycle 1 of the sweep.
   task automatic kick0();
      @(negedge clk);
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
   endtask

   task automatic kick1();
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
   endtask

   task automatic run0(input int p1, input int p2, output int c);
      int bad;
      bad = 0;
      c = 1;
      while (!done0 && c < 3000) begin
         if (!busy0 || done0) bad++;
         @(negedge clk);
         c++;
         start0 = (c == p1) || (c == p2);
      end
      start0 = 1'b0;
      chk("busy_whole_run", 32'(bad), 32'd0);
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      rst_n  = 1'b0;
      start0 = 1'b0;
      start1 = 1'b0;
      mode0  = 0;
      mode1  = 2;
      repeat (3) @(negedge clk);
      chk("rst_sab",   32'({s0, a0, b0}), 32'd0);
      chk("rst_busy",  32'(busy0), 32'd0);
      chk("rst_done",  32'(done0), 32'd0);
      chk("rst_pass",  32'(pass0), 32'd0);
      chk("rst_err",   32'(err0), 32'd0);
      chk("rst_fv",    32'(fv0), 32'd0);
      chk("rst_busy1", 32'(busy1), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_noresume", 32'(busy0), 32'd0);

      // Stop-on-fail: add fault trips on vector 0
      kick1();
      chk("halt_c1_busy", 32'(busy1), 32'd1);
      @(negedge clk);
      chk("halt_c2_busy", 32'(busy1), 32'd1);
      chk("halt_c2_done", 32'(done1), 32'd0);
      @(negedge clk);
      chk("halt_c3_done", 32'(done1), 32'd1);
      chk("halt_c3_busy", 32'(busy1), 32'd0);
      chk("halt_err",     32'(err1), 32'd1);
      chk("halt_fv",      32'(fv1), 32'h0001);
      chk("halt_pass",    32'(pass1), 32'd0);
      chk("halt_sab",     32'({s1, a1, b1}), 32'd0);

      // Clean full sweep
      kick0();
      run0(0, 0, cyc);
      chk("clean_done_cyc", 32'(cyc), 32'd1025);
      chk("clean_pass",     32'(pass0), 32'd1);
      chk("clean_err",      32'(err0), 32'd0);
      chk("clean_fv",       32'(fv0), 32'd0);
      chk("clean_hold_sab", 32'({s0, a0, b0}), 32'h3FF);

      // Restart from DONE with ignored mid-run start pulses
      kick0();
      chk("restart_done", 32'(done0), 32'd0);
      chk("restart_busy", 32'(busy0), 32'd1);
      chk("restart_sab",  32'({s0, a0, b0}), 32'd0);
      run0(10, 600, cyc);
      chk("pulse_done_cyc", 32'(cyc), 32'd1025);
      chk("pulse_pass",     32'(pass0), 32'd1);

      // AND and OR differ exactly when a != b: 240 per opcode
      mode0 = 1;
      kick0();
      run0(0, 0, cyc);
      chk("swap_done_cyc", 32'(cyc), 32'd1025);
      chk("swap_err",      32'(err0), 32'd480);
      chk("swap_fv",       32'(fv0), 32'h2011);
      chk("swap_pass",     32'(pass0), 32'd0);

      // Wrap: 15+1 must be 0, 0-1 must be 15
      mode0 = 3;
      kick0();
      chk("wrap_clr_err", 32'(err0), 32'd0);
      chk("wrap_clr_fv",  32'(fv0), 32'd0);
      run0(0, 0, cyc);
      chk("wrap_err",  32'(err0), 32'd2);
      chk("wrap_fv",   32'(fv0), 32'h0F11);
      chk("wrap_pass", 32'(pass0), 32'd0);

      // Asynchronous reset mid-sweep
      mode0 = 2;
      kick0();
      repeat (499) @(negedge clk);
      chk("mid_err_pre", 32'(err0), 32'd256);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_busy", 32'(busy0), 32'd0);
      chk("mid_done", 32'(done0), 32'd0);
      chk("mid_sab",  32'({s0, a0, b0}), 32'd0);
      chk("mid_err",  32'(err0), 32'd0);
      chk("mid_fv",   32'(fv0), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("mid_noresume", 32'(busy0), 32'd0);
      mode0 = 0;
      kick0();
      run0(0, 0, cyc);
      chk("mid_fresh_cyc",  32'(cyc), 32'd1025);
      chk("mid_fresh_pass", 32'(pass0), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
